// File: rtl/mdu_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master side issues operations and the slave side (mdu_iter) returns results.
interface mdu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [2:0]      function3;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] mdu_result;
  logic            busy;

  modport master (
    output in_valid, rs1, rs2, function3, kill, out_ready,
    input  in_ready, out_valid, mdu_result, busy
  );

  modport slave (
    input  in_valid, rs1, rs2, function3, kill, out_ready,
    output in_ready, out_valid, mdu_result, busy
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV-style M-extension unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with a sign fixup cycle and a held DONE result.
module mdu_iter #(
  parameter int XLEN         = 32,
  parameter int FAST_SPECIAL = 1
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);

  localparam int W2 = 2 * XLEN;
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    if (neg) begin
      r = ~v + XLEN'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Divide-by-zero and signed overflow results depend only on the dividend.
  function automatic logic [XLEN-1:0] special_result(input logic [2:0] fn,
                                                      input logic [XLEN-1:0] dividend,
                                                      input logic div0);
    logic [XLEN-1:0] r;
    if (div0) begin
      r = fn[1] ? dividend : {XLEN{1'b1}};
    end else begin
      r = fn[1] ? {XLEN{1'b0}} : dividend;
    end
    return r;
  endfunction

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic            setup_r;
  logic [XLEN-1:0] op_a_r;
  logic [2:0]      fn_r;
  logic [XLEN-1:0] a_mag_r;
  logic [XLEN-1:0] b_mag_r;
  logic            neg_res_r;
  logic            neg_rem_r;
  logic            div0_r;
  logic            ovf_r;
  logic [W2-1:0]   acc_r;
  logic            out_valid_r;
  logic [XLEN-1:0] mdu_result_r;

  logic            accept_s;
  logic            a_signed_s;
  logic            b_signed_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] a_mag_s;
  logic [XLEN-1:0] b_mag_s;
  logic            div0_s;
  logic            ovf_s;
  logic [XLEN:0]   mul_sum_s;
  logic [XLEN:0]   div_shift_s;
  logic            div_ge_s;
  logic [XLEN-1:0] div_diff_s;
  logic [W2-1:0]   iter_next_s;
  logic [W2-1:0]   prod_fix_s;
  logic [XLEN-1:0] fix_result_s;

  assign bus.in_ready   = (state_r == IDLE) && !bus.kill;
  assign bus.busy       = (state_r != IDLE);
  assign bus.out_valid  = out_valid_r;
  assign bus.mdu_result = mdu_result_r;
  assign accept_s       = bus.in_valid && bus.in_ready;

  // Operand decode at accept, one iteration step, and the sign fixup result.
  always_comb begin
    case (bus.function3)
      3'b001, 3'b100, 3'b110: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      3'b010: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
    a_neg_s = a_signed_s && bus.rs1[XLEN-1];
    b_neg_s = b_signed_s && bus.rs2[XLEN-1];
    a_mag_s = neg_if(a_neg_s, bus.rs1);
    b_mag_s = neg_if(b_neg_s, bus.rs2);
    div0_s  = bus.function3[2] && (bus.rs2 == {XLEN{1'b0}});
    ovf_s   = bus.function3[2] && !bus.function3[0] &&
              (bus.rs1 == MIN_NEG) && (bus.rs2 == {XLEN{1'b1}});

    // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
    mul_sum_s   = {1'b0, acc_r[W2-1:XLEN]} + (acc_r[0] ? {1'b0, a_mag_r} : {(XLEN+1){1'b0}});
    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    div_shift_s = acc_r[W2-1:XLEN-1];
    div_ge_s    = (div_shift_s >= {1'b0, b_mag_r});
    div_diff_s  = div_shift_s[XLEN-1:0] - b_mag_r;
    if (fn_r[2]) begin
      iter_next_s = {(div_ge_s ? div_diff_s : div_shift_s[XLEN-1:0]), acc_r[XLEN-2:0], div_ge_s};
    end else begin
      iter_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end

    prod_fix_s   = neg_res_r ? (~acc_r + W2'(1)) : acc_r;
    fix_result_s = {XLEN{1'b0}};
    if (div0_r || ovf_r) begin
      fix_result_s = special_result(fn_r, op_a_r, div0_r);
    end else begin
      case (fn_r)
        3'b000:                 fix_result_s = prod_fix_s[XLEN-1:0];
        3'b001, 3'b010, 3'b011: fix_result_s = prod_fix_s[W2-1:XLEN];
        3'b100, 3'b101:         fix_result_s = neg_if(neg_res_r, acc_r[XLEN-1:0]);
        3'b110, 3'b111:         fix_result_s = neg_if(neg_rem_r, acc_r[W2-1:XLEN]);
        default:                fix_result_s = {XLEN{1'b0}};
      endcase
    end
  end

  // Control FSM with the iteration datapath and registered result/valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      setup_r      <= 1'b0;
      op_a_r       <= {XLEN{1'b0}};
      fn_r         <= 3'b000;
      a_mag_r      <= {XLEN{1'b0}};
      b_mag_r      <= {XLEN{1'b0}};
      neg_res_r    <= 1'b0;
      neg_rem_r    <= 1'b0;
      div0_r       <= 1'b0;
      ovf_r        <= 1'b0;
      acc_r        <= {W2{1'b0}};
      out_valid_r  <= 1'b0;
      mdu_result_r <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_a_r    <= bus.rs1;
            fn_r      <= bus.function3;
            a_mag_r   <= a_mag_s;
            b_mag_r   <= b_mag_s;
            neg_res_r <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            div0_r    <= div0_s;
            ovf_r     <= ovf_s;
            setup_r   <= 1'b1;
            cnt_r     <= {CW{1'b0}};
            state_r   <= BUSY;
          end
        end
        BUSY: begin
          if (bus.kill) begin
            setup_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
          end else if (setup_r) begin
            // First cycle after accept seeds the accumulator or short-circuits special divides.
            setup_r <= 1'b0;
            if ((FAST_SPECIAL != 0) && (div0_r || ovf_r)) begin
              mdu_result_r <= special_result(fn_r, op_a_r, div0_r);
              out_valid_r  <= 1'b1;
              state_r      <= DONE;
            end else if (fn_r[2]) begin
              acc_r <= {{XLEN{1'b0}}, a_mag_r};
            end else begin
              acc_r <= {{XLEN{1'b0}}, b_mag_r};
            end
          end else begin
            acc_r <= iter_next_s;
            if (cnt_r == CNT_LAST) begin
              cnt_r   <= {CW{1'b0}};
              state_r <= FIXUP;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        FIXUP: begin
          if (bus.kill) begin
            state_r <= IDLE;
          end else begin
            mdu_result_r <= fix_result_s;
            out_valid_r  <= 1'b1;
            state_r      <= DONE;
          end
        end
        DONE: begin
          if (bus.kill || bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and random checks of mdu_iter (XLEN=32, FAST_SPECIAL=1): results, latency,
// backpressure, kill and asynchronous reset behaviour.
module tb_mdu_iter;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 22;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  vec_t vt[NV];

  mdu_if #(.XLEN(32)) bus ();

  mdu_iter #(.XLEN(32), .FAST_SPECIAL(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] golden(input logic [2:0] fn, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    case (fn)
      3'd0: begin p = {32'd0, a} * {32'd0, b};               r = p[31:0];  end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};   r = p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b};         r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b};               r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == MIN_NEG && b == 32'hFFFF_FFFF) r = a;
        else r = $signed(a) / $signed(b);
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == MIN_NEG && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int golden_lat(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    if (fn[2] && ((b == 32'd0) || (!fn[0] && a == MIN_NEG && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  task automatic start_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.function3 = fn;
    bus.rs1       = a;
    bus.rs2       = b;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.rs1       = $urandom;
    bus.rs2       = $urandom;
    bus.function3 = 3'($urandom);
  endtask

  task automatic wait_valid(input string tag, output int edges);
    edges = 0;
    while (!bus.out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input string tag);
    int edges;
    bus.out_ready = 1'b0;
    start_op(fn, a, b);
    wait_valid(tag, edges);
    check({tag, " latency"}, 32'(edges), 32'(exp_lat));
    check({tag, " result"}, bus.mdu_result, exp_res);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " release"}, 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          edges;
    int          seen;
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] held;

    n_cmp = 0;
    n_err = 0;
    vt[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 34};
    vt[1]  = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 34};
    vt[2]  = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vt[3]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
    vt[4]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vt[5]  = '{3'b101, 32'd100,       32'd7,         32'd14,        34};
    vt[6]  = '{3'b111, 32'd100,       32'd7,         32'd2,         34};
    vt[7]  = '{3'b100, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vt[8]  = '{3'b110, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1};
    vt[9]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vt[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vt[11] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    vt[12] = '{3'b010, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vt[13] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
    vt[14] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34};
    vt[15] = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 34};
    vt[16] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vt[17] = '{3'b111, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 1};
    vt[18] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vt[19] = '{3'b110, 32'hFFFF_FFF8, 32'h0000_0003, 32'hFFFF_FFFE, 34};
    vt[20] = '{3'b101, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 34};
    vt[21] = '{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.rs1       = 32'd0;
    bus.rs2       = 32'd0;
    bus.function3 = 3'b000;
    bus.kill      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset mdu_result", bus.mdu_result, 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].fn, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 10 cycles while a competing request is presented.
    start_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_valid("bp", edges);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.function3 = 3'b011;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp out_valid held", 32'(bus.out_valid), 32'd1);
      check("bp result held", bus.mdu_result, 32'hFFFF_FFFE);
      check("bp in_ready low", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp released out_valid", 32'(bus.out_valid), 32'd0);
    check("bp released in_ready", 32'(bus.in_ready), 32'd1);
    check("bp no stray accept", 32'(bus.busy), 32'd0);
    bus.out_ready = 1'b0;

    // Kill during DIVU iterations, then a fresh MULHSU.
    start_op(3'b101, 32'd1000, 32'd3);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("kill pre busy", 32'(bus.busy), 32'd1);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    check("kill busy", 32'(bus.busy), 32'd0);
    check("kill out_valid", 32'(bus.out_valid), 32'd0);
    check("kill in_ready gated", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.kill = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("kill no late out_valid", 32'(seen), 32'd0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "post-kill mulhsu");

    // Kill in IDLE blocks acceptance.
    @(negedge clk);
    bus.kill      = 1'b1;
    bus.in_valid  = 1'b1;
    bus.function3 = 3'b000;
    #1;
    check("idle kill in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("idle kill no accept", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.kill     = 1'b0;
    bus.in_valid = 1'b0;

    // Kill together with out_ready in DONE discards the result.
    start_op(3'b101, 32'd100, 32'd7);
    wait_valid("kill+ready", edges);
    @(negedge clk);
    bus.kill      = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("kill+ready out_valid", 32'(bus.out_valid), 32'd0);
    check("kill+ready busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.kill      = 1'b0;
    bus.out_ready = 1'b0;
    held = bus.mdu_result;
    check("kill+ready last result", held, 32'd14);

    // Asynchronous reset mid-BUSY.
    start_op(3'b100, 32'h0000_1234, 32'h0000_0011);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst mdu_result", bus.mdu_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post-rst in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || bus.busy) seen++;
    end
    check("post-rst quiet", 32'(seen), 32'd0);

    // Random operations against the reference model.
    for (int i = 0; i < 200; i++) begin
      fn = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      run_op(fn, a, b, golden(fn, a, b), golden_lat(fn, a, b), $sformatf("rnd%0d f%0d", i, fn));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
